// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute-to-memory pipeline stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ex_mem_stage_pkg;

    // Encoding of the in_sel result-select field.
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_SHT  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    // Datapath width of the canonical payload layout below.
    localparam int PL_DW = 32;

    // Stage payload, most significant field first. The top packs a flat
    // vector in this exact field order for any DW, so the skid buffer stays
    // width-generic.
    typedef struct packed {
        logic [PL_DW-1:0] res;
        logic [4:0]       rd;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
        logic [PL_DW-1:0] store_data;
    } ex_mem_pl_t;

    // Width of the packed payload for a given datapath width.
    function automatic int pl_width(input int dw);
        return 2 * dw + 8;
    endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Generic two-entry skid buffer (head drives output, skid catches overflow).
// Latency: 1 cycle from accept to out_valid when empty.
// Backpressure: in_ready = !skid_valid from registered state; no comb path from out_ready.
module ex_mem_skid
    import ex_mem_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] head;
    logic [W-1:0] skid;
    logic         accept;
    logic         pop;
    logic         load_head_in;
    logic         load_skid_in;
    logic         load_head_skid;

    // Handshake flags come purely from the state register.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = head;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state and payload-steering decode; flush overrides everything.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_head_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (pop && accept) begin
                    load_head_in = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    state_nxt    = FULL;
                    load_skid_in = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_head_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_head_skid = 1'b0;
        end
    end

    // State register; reset drops every held beat without needing a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload registers; head only changes on a load so it is stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in) begin
                head <= in_data;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid_in) begin
                skid <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: result select, rd0 write gating, optional forwarding (EX_MEM_FWD_EN).
// Latency: 1 cycle accept to out_valid when empty; two-entry skid absorbs one stall beat.
// Backpressure: in_ready drops only when both entries are held; registered, no path from out_ready.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_sel,
    input  logic [DW-1:0] alu_res,
    input  logic [DW-1:0] sht_res,
    input  logic [DW-1:0] link_addr,
    input  logic [4:0]    rd,
    input  logic          reg_we,
    input  logic          mem_re,
    input  logic          mem_we,
    input  logic [DW-1:0] store_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_res,
    output logic [4:0]    out_rd,
    output logic          out_reg_we,
    output logic          out_mem_re,
    output logic          out_mem_we,
    output logic [DW-1:0] out_store_data
`ifdef EX_MEM_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [4:0]    fwd_rd,
    output logic [DW-1:0] fwd_data,
    output logic          fwd_load_hazard
`endif
);

    localparam int PW = pl_width(DW);

    logic [DW-1:0] sel_res;
    logic          reg_we_eff;
    logic [PW-1:0] pl_in;
    logic [PW-1:0] pl_out;

    // Pick the stage result; the zero select exists for ops with no writeback value.
    always_comb begin
        sel_res = '0;
        case (in_sel)
            SEL_ALU:  sel_res = alu_res;
            SEL_SHT:  sel_res = sht_res;
            SEL_LINK: sel_res = link_addr;
            SEL_ZERO: sel_res = '0;
            default:  sel_res = '0;
        endcase
    end

    // x0 is hardwired zero, so a write to it is dropped at capture.
    assign reg_we_eff = reg_we & (rd != 5'd0);

    assign pl_in = {sel_res, rd, reg_we_eff, mem_re, mem_we, store_data};

    ex_mem_skid #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pl_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pl_out)
    );

    assign {out_res, out_rd, out_reg_we, out_mem_re, out_mem_we, out_store_data} = pl_out;

`ifdef EX_MEM_FWD_EN
    // Loads have no data yet at this stage, so they raise a hazard instead of forwarding.
    assign fwd_valid       = out_valid & out_reg_we & ~out_mem_re;
    assign fwd_rd          = out_rd;
    assign fwd_data        = out_res;
    assign fwd_load_hazard = out_valid & out_mem_re & (out_rd != 5'd0);
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic vs a queue model.
// Latency: checks 1-cycle accept-to-valid and in-order delivery.
// Backpressure: random out_ready stalls and flushes exercise the skid path.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] alu_res;
    logic [31:0] sht_res;
    logic [31:0] link_addr;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] store_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic        out_mem_re;
    logic        out_mem_we;
    logic [31:0] out_store_data;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        fwd_load_hazard;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [31:0] sd;
    } beat_t;

    beat_t q[$];

    ex_mem_stage #(.DW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sel         (in_sel),
        .alu_res        (alu_res),
        .sht_res        (sht_res),
        .link_addr      (link_addr),
        .rd             (rd),
        .reg_we         (reg_we),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .store_data     (store_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_res        (out_res),
        .out_rd         (out_rd),
        .out_reg_we     (out_reg_we),
        .out_mem_re     (out_mem_re),
        .out_mem_we     (out_mem_we),
        .out_store_data (out_store_data)
`ifdef EX_MEM_FWD_EN
        ,
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
        .fwd_load_hazard (fwd_load_hazard)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [1:0] s, input logic [31:0] a, input logic [31:0] sh,
                              input logic [31:0] l, input logic [4:0] r, input logic we,
                              input logic re, input logic mwe, input logic [31:0] sd);
        in_valid   = 1'b1;
        in_sel     = s;
        alu_res    = a;
        sht_res    = sh;
        link_addr  = l;
        rd         = r;
        reg_we     = we;
        mem_re     = re;
        mem_we     = mwe;
        store_data = sd;
    endtask

    // Reference: what the stage should deliver for the beat currently on the inputs.
    function automatic beat_t expect_beat();
        beat_t b;
        case (in_sel)
            2'd0:    b.res = alu_res;
            2'd1:    b.res = sht_res;
            2'd2:    b.res = link_addr;
            default: b.res = 32'd0;
        endcase
        b.rd     = rd;
        b.reg_we = reg_we && (rd != 5'd0);
        b.mem_re = mem_re;
        b.mem_we = mem_we;
        b.sd     = store_data;
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_beat(2'd0, 32'hDEAD_BEEF, 32'h1, 32'h2, 5'd9, 1'b1, 1'b0, 1'b0, 32'h55);
        in_valid = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if ({out_res, out_rd, out_reg_we, out_mem_re, out_mem_we, out_store_data} !== 72'd0) begin
            errors++; $display("FAIL reset_payload got %h/%0d/%b%b%b/%h want all 0", out_res, out_rd,
                               out_reg_we, out_mem_re, out_mem_we, out_store_data);
        end
`ifdef EX_MEM_FWD_EN
        checks++;
        if ({fwd_valid, fwd_rd, fwd_data, fwd_load_hazard} !== 39'd0) begin
            errors++; $display("FAIL reset_fwd got %b/%0d/%h/%b want all 0", fwd_valid, fwd_rd, fwd_data, fwd_load_hazard);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive_beat(2'd1, 32'h1111, 32'h0000_00F0, 32'h2222, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_res !== 32'h0000_00F0) begin errors++; $display("FAIL single_res got %h want 000000f0", out_res); end
        checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL single_rd got %0d want 3", out_rd); end
        checks++; if (out_reg_we !== 1'b1) begin errors++; $display("FAIL single_reg_we got %b want 1", out_reg_we); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_beat(2'd0, 32'hA0, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        drive_beat(2'd0, 32'hB0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b want 1", in_ready); end
        cyc();
        drive_beat(2'd0, 32'hC0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        cyc();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold got %b want 0", in_ready); end
        checks++; if (out_res !== 32'hA0) begin errors++; $display("FAIL bp_head_stable got %h want a0", out_res); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_res !== 32'hA0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%b want a0/1", out_res, out_valid); end
        cyc();
        checks++; if (out_res !== 32'hB0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got %h/%b want b0/1", out_res, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got %b want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (out_res !== 32'hC0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got %h/%b want c0/1", out_res, out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_rd_zero();
        out_ready = 1'b1;
        drive_beat(2'd0, 32'h1234, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_res !== 32'h1234) begin errors++; $display("FAIL rd0_beat got %b/%h want 1/1234", out_valid, out_res); end
        checks++; if (out_reg_we !== 1'b0) begin errors++; $display("FAIL rd0_reg_we got %b want 0", out_reg_we); end
`ifdef EX_MEM_FWD_EN
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rd0_fwd_valid got %b want 0", fwd_valid); end
`endif
        cyc();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_beat(2'd2, 32'h0, 32'h0, 32'hF1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        drive_beat(2'd2, 32'h0, 32'h0, 32'hF2, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        drive_beat(2'd2, 32'h0, 32'h0, 32'hF3, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %b want 0", in_ready); end
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready_after got %b want 1", in_ready); end
        // Flush from ONE while a new beat is offered: that beat must be dropped too.
        drive_beat(2'd0, 32'hF4, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        drive_beat(2'd0, 32'hF5, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle %0d got valid %b res %h want 0", i, out_valid, out_res); end
            cyc();
        end
    endtask

    task automatic test_load_sel_zero();
        out_ready = 1'b0;
        drive_beat(2'd3, 32'h7777, 32'h8888, 32'h9999, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_res !== 32'd0) begin errors++; $display("FAIL load_sel0 got %b/%h want 1/0", out_valid, out_res); end
        checks++; if (out_mem_re !== 1'b1 || out_rd !== 5'd7) begin errors++; $display("FAIL load_ctl got %b/%0d want 1/7", out_mem_re, out_rd); end
`ifdef EX_MEM_FWD_EN
        checks++; if (fwd_load_hazard !== 1'b1) begin errors++; $display("FAIL load_hazard got %b want 1", fwd_load_hazard); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL load_fwd_valid got %b want 0", fwd_valid); end
`endif
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_drain got %b want 0", out_valid); end
`ifdef EX_MEM_FWD_EN
        checks++; if (fwd_load_hazard !== 1'b0) begin errors++; $display("FAIL load_hazard_clear got %b want 0", fwd_load_hazard); end
`endif
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_beat(2'd0, 32'hAA, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 32'h77);
        cyc();
        drive_beat(2'd0, 32'hBB, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 32'h88);
        cyc();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", in_ready); end
        checks++; if (out_res !== 32'd0 || out_store_data !== 32'd0) begin errors++; $display("FAIL arst_payload got %h/%h want 0/0", out_res, out_store_data); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        drive_beat(2'd2, 32'h0, 32'h0, 32'h4000_0004, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_res !== 32'h4000_0004) begin errors++; $display("FAIL arst_first got %b/%h want 1/40000004", out_valid, out_res); end
        cyc();
    endtask

    task automatic test_random();
        beat_t exp_b;
        logic  acc;
        logic  pop;
        q.delete();
        for (int i = 0; i < 2000; i++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            in_sel     = 2'($urandom_range(0, 3));
            alu_res    = $urandom;
            sht_res    = $urandom;
            link_addr  = $urandom;
            rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            reg_we     = 1'($urandom_range(0, 1));
            mem_re     = 1'($urandom_range(0, 1));
            mem_we     = 1'($urandom_range(0, 1));
            store_data = $urandom;
            @(negedge clk);
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                checks++;
                if ({out_res, out_rd, out_reg_we, out_mem_re, out_mem_we, out_store_data} !==
                    {q[0].res, q[0].rd, q[0].reg_we, q[0].mem_re, q[0].mem_we, q[0].sd}) begin
                    errors++;
                    $display("FAIL rnd_payload cyc %0d got %h/%0d/%b%b%b/%h want %h/%0d/%b%b%b/%h", i,
                             out_res, out_rd, out_reg_we, out_mem_re, out_mem_we, out_store_data,
                             q[0].res, q[0].rd, q[0].reg_we, q[0].mem_re, q[0].mem_we, q[0].sd);
                end
`ifdef EX_MEM_FWD_EN
                checks++;
                if ({fwd_valid, fwd_rd, fwd_data, fwd_load_hazard} !==
                    {q[0].reg_we && !q[0].mem_re, q[0].rd, q[0].res, q[0].mem_re && (q[0].rd != 5'd0)}) begin
                    errors++;
                    $display("FAIL rnd_fwd cyc %0d got %b/%0d/%h/%b", i, fwd_valid, fwd_rd, fwd_data, fwd_load_hazard);
                end
`endif
            end
            acc   = in_valid && (q.size() < 2);
            pop   = out_ready && (q.size() > 0);
            exp_b = expect_beat();
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(exp_b);
            end
            cyc();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_rd_zero();
        test_flush();
        test_load_sel_zero();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the datapath width of all result and store-data buses.
REQ-002 The block SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1, synchronous pipeline kill.
REQ-005 The block SHALL have port in_valid, input, 1, execute-stage beat present.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a beat.
REQ-007 The block SHALL have port in_sel, input, 2, result select: 00 ALU, 01 shifter, 10 link, 11 zero.
REQ-008 The block SHALL have ports alu_res, sht_res and link_addr, each input, DW, candidate results.
REQ-009 The block SHALL have ports rd, input, 5, destination register; reg_we, mem_re and mem_we, each input, 1, control bits.
REQ-010 The block SHALL have port store_data, input, DW, store operand.
REQ-011 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1, forming the downstream handshake.
REQ-012 The block SHALL have ports out_res, output, DW; out_rd, output, 5; out_reg_we, out_mem_re and out_mem_we, each output, 1; and out_store_data, output, DW.
REQ-013 The block SHALL have ports fwd_valid, output, 1; fwd_rd, output, 5; fwd_data, output, DW; and fwd_load_hazard, output, 1, present only with FWD_EN.

Function
REQ-014 The block SHALL compute the selected result at capture: sel 00 gives alu_res, 01 gives sht_res, 10 gives link_addr, 11 gives 0.
REQ-015 The block SHALL force the stored reg_we to 0 when rd equals 0.
REQ-016 The block SHALL hold two entries, head and skid; out_* SHALL be driven from head only.
REQ-017 An accept SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-018 in_ready SHALL equal NOT skid_valid, taken from registered state only with no combinational path from out_ready.
REQ-019 States: EMPTY (no entries), ONE (head only) and FULL (head and skid).
REQ-020 From EMPTY, accept SHALL go to ONE; with no accept the block SHALL stay in EMPTY.
REQ-021 From ONE: pop with accept SHALL stay in ONE with new head; pop only SHALL go to EMPTY; accept only SHALL go to FULL with the beat in skid; neither SHALL hold.
REQ-022 From FULL, pop SHALL move skid to head and go to ONE; no accept is possible in FULL.
REQ-023 Latency SHALL be 1 cycle, accept to out_valid, when EMPTY.
REQ-024 Head payload SHALL be stable while out_valid is 1 and out_ready is 0.
REQ-025 Flush SHALL clear both valid bits on the next edge, discard any beat accepted in the same cycle, and take priority over accept and pop.
REQ-026 Beat order SHALL be preserved; no beat SHALL be duplicated or dropped except by flush.

Reset
REQ-027 While rst_n is 0, all valid bits and payload registers SHALL be 0, out_valid SHALL be 0, in_ready SHALL be 1, and FWD_EN outputs SHALL be 0.
REQ-028 Reset assertion mid-transfer SHALL discard all held beats immediately, with no clock required.

Configuration
REQ-029 With macro EX_MEM_FWD_EN defined: fwd_valid SHALL equal head_valid AND out_reg_we AND NOT out_mem_re; fwd_rd SHALL equal out_rd; fwd_data SHALL equal out_res; fwd_load_hazard SHALL equal head_valid AND out_mem_re AND out_rd not equal to 0.
REQ-030 Without EX_MEM_FWD_EN, the four fwd ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package SHALL hold the in_sel encoding constants (SEL_ALU, SEL_SHT, SEL_LINK, SEL_ZERO) and the stage payload struct (res, rd, reg_we, mem_re, mem_we, store_data).
REQ-032 The block SHALL contain one sub-module, ex_mem_skid, a generic two-entry skid buffer parameterised on payload width; result select and forwarding SHALL stay in ex_mem_stage.

Verification
REQ-033 Reset then a single beat (sel 01, sht_res 0x0000_00F0, rd 3, reg_we 1) with out_ready held 1 -> out_valid 1 one cycle later, out_res 0x0000_00F0, out_rd 3.
REQ-034 out_ready held 0 while 3 beats are offered -> 2 accepted, in_ready 0 afterwards, third beat held upstream; out_ready raised -> all 3 delivered in order, one per cycle.
REQ-035 rd 0 with reg_we 1 and sel 00, alu_res 0x1234 -> out_reg_we 0 and, with EX_MEM_FWD_EN, fwd_valid 0.
REQ-036 FULL state with flush and in_valid both 1 -> next cycle out_valid 0 and in_ready 1; no flushed beat ever appears downstream.
REQ-037 Load beat (mem_re 1, rd 7) in head with EX_MEM_FWD_EN -> fwd_load_hazard 1 and fwd_valid 0; sel 11 -> out_res 0.
REQ-038 rst_n pulled low between clock edges while FULL -> out_valid 0 immediately; first beat after release delivered with 1-cycle latency.
